// File: rtl/middle_ram_frame_ctrl_if.sv
// Stream, status and RAM-port signals of the middle_ram frame controller.
// The environment side (upstream, downstream and the RAM itself) uses master; the controller uses slave.
interface middle_ram_frame_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_wraddress;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_rdaddress;
    logic [DATA_W-1:0] ram_q;

    modport master (
        output start, in_valid, in_data, out_ready, ram_q,
        input  in_ready, out_valid, out_data, out_last, busy, done,
               ram_wraddress, ram_wren, ram_data, ram_rdaddress
    );

    modport slave (
        input  start, in_valid, in_data, out_ready, ram_q,
        output in_ready, out_valid, out_data, out_last, busy, done,
               ram_wraddress, ram_wren, ram_data, ram_rdaddress
    );
endinterface

// File: rtl/middle_ram_frame_ctrl.sv
// Captures one raster-order frame into middle_ram, then replays it downstream
// through a 2-entry skid FIFO that absorbs the RAM's 1-cycle read latency.
module middle_ram_frame_ctrl #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FRAME_PIXELS = 65536
) (
    input  logic                  clock,
    input  logic                  reset,
    middle_ram_frame_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_rd_done;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_head;
    logic [1:0]        r_count;
    logic              r_done;

    logic              w_accept;
    logic              w_pop;
    logic              w_final_pop;
    logic              w_issue;
    logic              w_tail;
    logic [1:0]        w_occ;

    assign w_accept    = (r_state == S_FILL) && bus.in_valid;
    assign w_pop       = (r_count != 2'd0) && bus.out_ready;
    assign w_final_pop = w_pop && r_fifo_last[r_head];
    assign w_tail      = r_head ^ r_count[0];
    // Slots committed after this cycle: queued + arriving - leaving; a read may claim a free one.
    assign w_occ       = r_count + 2'(r_inflight) - 2'(w_pop);
    assign w_issue     = (r_state == S_DRAIN) && !r_rd_done && (w_occ < 2'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_FILL;
            S_FILL:  if (w_accept && (r_wr_ptr == LAST_ADDR)) w_state_next = S_DRAIN;
            S_DRAIN: if (w_final_pop) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pointers hold at the terminal address so a full 2**ADDR_W frame never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_rd_done       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= 2'b00;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
            r_done          <= 1'b0;
        end else begin
            r_done <= w_final_pop;

            if ((r_state == S_IDLE) && bus.start) begin
                r_wr_ptr <= '0;
            end else if (w_accept && (r_wr_ptr != LAST_ADDR)) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end

            if (w_final_pop) begin
                r_rd_ptr  <= '0;
                r_rd_done <= 1'b0;
            end else if (w_issue) begin
                if (r_rd_ptr == LAST_ADDR) begin
                    r_rd_done <= 1'b1;
                end else begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
            end

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_ptr == LAST_ADDR);

            if (r_inflight) begin
                r_fifo_data[w_tail] <= bus.ram_q;
                r_fifo_last[w_tail] <= r_inflight_last;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= w_occ;
        end
    end

    assign bus.in_ready      = (r_state == S_FILL);
    assign bus.ram_wren      = w_accept;
    assign bus.ram_wraddress = r_wr_ptr;
    assign bus.ram_data      = bus.in_data;
    assign bus.ram_rdaddress = r_rd_ptr;
    assign bus.out_valid     = (r_count != 2'd0);
    assign bus.out_data      = r_fifo_data[r_head];
    assign bus.out_last      = (r_count != 2'd0) && r_fifo_last[r_head];
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = r_done;
endmodule

// File: tb/tb_middle_ram_frame_ctrl.sv
// Bench for middle_ram_frame_ctrl: three instances (50-pixel frame, full 2**ADDR_W frame,
// single-pixel frame) sharing stimulus, each backed by a behavioural 1-cycle-latency RAM.
module tb_middle_ram_frame_ctrl;
    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    int errors = 0;
    int checks = 0;

    middle_ram_frame_ctrl_if #(.ADDR_W(16), .DATA_W(8)) ifa ();
    middle_ram_frame_ctrl_if #(.ADDR_W(8),  .DATA_W(8)) ifb ();
    middle_ram_frame_ctrl_if #(.ADDR_W(4),  .DATA_W(8)) ifc ();

    middle_ram_frame_ctrl #(.ADDR_W(16), .DATA_W(8), .FRAME_PIXELS(50))
        dut_a (.clock(clk), .reset(rst), .bus(ifa));
    middle_ram_frame_ctrl #(.ADDR_W(8), .DATA_W(8), .FRAME_PIXELS(256))
        dut_b (.clock(clk), .reset(rst), .bus(ifb));
    middle_ram_frame_ctrl #(.ADDR_W(4), .DATA_W(8), .FRAME_PIXELS(1))
        dut_c (.clock(clk), .reset(rst), .bus(ifc));

    assign ifa.start = start && (sel == 2'd0);
    assign ifb.start = start && (sel == 2'd1);
    assign ifc.start = start && (sel == 2'd2);
    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;  assign ifc.in_valid = in_valid;
    assign ifa.in_data  = in_data;   assign ifb.in_data  = in_data;   assign ifc.in_data  = in_data;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifc.out_ready = out_ready;

    // Behavioural middle_ram models: registered read, write visible on later reads.
    logic [7:0] ram_a [0:65535];
    logic [7:0] ram_b [0:255];
    logic [7:0] ram_c [0:15];
    logic [7:0] q_a, q_b, q_c;
    assign ifa.ram_q = q_a;
    assign ifb.ram_q = q_b;
    assign ifc.ram_q = q_c;

    initial begin
        for (int i = 0; i < 65536; i++) ram_a[i] = 8'hEE;
        for (int i = 0; i < 256; i++) ram_b[i] = 8'hEE;
        for (int i = 0; i < 16; i++) ram_c[i] = 8'hEE;
    end

    always @(posedge clk) begin
        if (ifa.ram_wren) ram_a[ifa.ram_wraddress] <= ifa.ram_data;
        if (ifb.ram_wren) ram_b[ifb.ram_wraddress] <= ifb.ram_data;
        if (ifc.ram_wren) ram_c[ifc.ram_wraddress] <= ifc.ram_data;
        q_a <= ram_a[ifa.ram_rdaddress];
        q_b <= ram_b[ifb.ram_rdaddress];
        q_c <= ram_c[ifc.ram_rdaddress];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs of the instance under test.
    logic        o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_wren;
    logic [7:0]  o_out_data, o_ram_data;
    logic [15:0] o_wraddr, o_rdaddr;

    always_comb begin
        case (sel)
            2'd0: begin
                o_in_ready = ifa.in_ready; o_out_valid = ifa.out_valid; o_out_last = ifa.out_last;
                o_busy = ifa.busy; o_done = ifa.done; o_wren = ifa.ram_wren;
                o_out_data = ifa.out_data; o_ram_data = ifa.ram_data;
                o_wraddr = ifa.ram_wraddress; o_rdaddr = ifa.ram_rdaddress;
            end
            2'd1: begin
                o_in_ready = ifb.in_ready; o_out_valid = ifb.out_valid; o_out_last = ifb.out_last;
                o_busy = ifb.busy; o_done = ifb.done; o_wren = ifb.ram_wren;
                o_out_data = ifb.out_data; o_ram_data = ifb.ram_data;
                o_wraddr = 16'(ifb.ram_wraddress); o_rdaddr = 16'(ifb.ram_rdaddress);
            end
            default: begin
                o_in_ready = ifc.in_ready; o_out_valid = ifc.out_valid; o_out_last = ifc.out_last;
                o_busy = ifc.busy; o_done = ifc.done; o_wren = ifc.ram_wren;
                o_out_data = ifc.out_data; o_ram_data = ifc.ram_data;
                o_wraddr = 16'(ifc.ram_wraddress); o_rdaddr = 16'(ifc.ram_rdaddress);
            end
        endcase
    end

    function automatic logic [7:0] pix(input int pat, input int idx);
        case (pat)
            0:       return 8'(idx);
            1:       return ~8'(idx);
            2:       return 8'($urandom);
            default: return 8'h5A;
        endcase
    endfunction

    // Runs one frame on instance s; the expected replay is the queue of accepted pixels.
    // gap_pct<0 toggles in_valid; rst_k>=0 resets during replay at that output index.
    task automatic run_frame(input int s, input int n, input int pat, input int gap_pct,
                             input int ready_pct, input int stall_k, input bit poke,
                             input int rst_k, input bit chk_timing);
        logic [7:0] exp_q [$];
        int idx, k, cyc, stall_cnt, prev_rd;
        bit hs;
        sel = 2'(s);
        @(negedge clk); start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < n && cyc < 4000) begin
            in_valid = (gap_pct < 0) ? (cyc % 2 == 0) : (int'($urandom_range(99)) >= gap_pct);
            in_data  = pix(pat, idx);
            start    = poke && (idx == 10);
            #1;
            checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready: got %b need 1", o_in_ready); end
            checks++; if (o_wren !== in_valid) begin errors++; $display("FAIL fill_wren: got %b need %b", o_wren, in_valid); end
            if (in_valid) begin
                checks++;
                if (o_wraddr !== 16'(idx) || o_ram_data !== in_data) begin
                    errors++; $display("FAIL fill_write: got addr %0h data %0h need addr %0h data %0h", o_wraddr, o_ram_data, idx, in_data);
                end
            end
            @(posedge clk);
            if (in_valid) begin exp_q.push_back(in_data); idx++; end
            @(negedge clk); cyc++;
        end
        checks++; if (idx != n) begin errors++; $display("FAIL fill_timeout: got %0d pixels need %0d", idx, n); end
        in_valid = 1'b1; start = 1'b0; k = 0; cyc = 0; stall_cnt = 0; prev_rd = 0;
        while (k < n && cyc < 4000) begin
            if (rst_k >= 0 && k == rst_k) begin
                rst = 1'b1; #1;
                checks++;
                if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_rdaddr !== 16'h0 || o_wren !== 1'b0) begin
                    errors++; $display("FAIL drain_reset: got valid %b busy %b rdaddr %0h wren %b need 0 0 0 0", o_out_valid, o_busy, o_rdaddr, o_wren);
                end
                @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                return;
            end
            if (k == stall_k && stall_cnt < 5) begin out_ready = 1'b0; stall_cnt++; end
            else out_ready = (int'($urandom_range(99)) < ready_pct);
            start = poke && (k == 5);
            #1;
            checks++;
            if (o_in_ready !== 1'b0 || o_wren !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
                errors++; $display("FAIL drain_status: got in_ready %b wren %b busy %b done %b need 0 0 1 0", o_in_ready, o_wren, o_busy, o_done);
            end
            checks++;
            if (int'(o_rdaddr) < prev_rd || int'(o_rdaddr) > n - 1) begin
                errors++; $display("FAIL drain_rdaddr: got %0h prev %0h limit %0h", o_rdaddr, prev_rd, n - 1);
            end
            prev_rd = int'(o_rdaddr);
            if (chk_timing) begin
                checks++;
                if (o_out_valid !== (cyc >= 2)) begin
                    errors++; $display("FAIL drain_timing: cycle %0d got valid %b need %b", cyc, o_out_valid, cyc >= 2);
                end
            end
            checks++;
            if (o_out_valid === 1'b1) begin
                if (o_out_data !== exp_q[k] || o_out_last !== (k == n - 1)) begin
                    errors++; $display("FAIL drain_data: idx %0d got %0h last %b need %0h last %b", k, o_out_data, o_out_last, exp_q[k], k == n - 1);
                end
            end else if (o_out_last !== 1'b0) begin
                errors++; $display("FAIL drain_last_idle: got %b need 0", o_out_last);
            end
            hs = (o_out_valid === 1'b1) && out_ready;
            @(posedge clk);
            if (hs) k++;
            @(negedge clk); cyc++;
        end
        checks++; if (k != n) begin errors++; $display("FAIL drain_timeout: got %0d pixels need %0d", k, n); end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got done %b busy %b valid %b in_ready %b need 1 0 0 0", o_done, o_busy, o_out_valid, o_in_ready);
        end
        @(negedge clk); #1;
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_width: got %b need 0", o_done); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; sel = 2'd0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        checks++;
        if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_out_last !== 1'b0 || o_busy !== 1'b0 ||
            o_done !== 1'b0 || o_wren !== 1'b0 || o_wraddr !== 16'h0 || o_rdaddr !== 16'h0) begin
            errors++; $display("FAIL reset_values: got rdy %b vld %b last %b busy %b done %b wren %b wa %0h ra %0h need all 0",
                o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_wren, o_wraddr, o_rdaddr);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        checks++; if (o_busy !== 1'b1 || o_wraddr !== 16'h4) begin errors++; $display("FAIL pre_reset_fill: got busy %b wa %0h need 1 4", o_busy, o_wraddr); end
        #1 rst = 1'b1; #1;
        checks++;
        if (o_in_ready !== 1'b0 || o_busy !== 1'b0 || o_wren !== 1'b0 || o_wraddr !== 16'h0 || o_out_valid !== 1'b0) begin
            errors++; $display("FAIL midclock_reset: got rdy %b busy %b wren %b wa %0h vld %b need 0 0 0 0 0",
                o_in_ready, o_busy, o_wren, o_wraddr, o_out_valid);
        end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_frame_basic;
        run_frame(0, 50, 0, 0, 100, -1, 1'b0, -1, 1'b1);
    endtask

    task automatic test_backpressure;
        run_frame(0, 50, 0, -1, 100, 10, 1'b0, -1, 1'b0);
        run_frame(0, 50, 2, 30, 60, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_start_ignored;
        run_frame(0, 50, 2, 20, 80, -1, 1'b1, -1, 1'b0);
        run_frame(0, 50, 0, 0, 100, -1, 1'b0, -1, 1'b1);
    endtask

    task automatic test_reset_in_drain;
        run_frame(0, 50, 0, 0, 100, -1, 1'b0, 20, 1'b0);
        run_frame(0, 50, 1, 0, 100, -1, 1'b0, -1, 1'b1);
    endtask

    task automatic test_full_range;
        run_frame(1, 256, 0, 10, 90, -1, 1'b0, -1, 1'b0);
        run_frame(1, 256, 1, 0, 100, -1, 1'b0, -1, 1'b1);
    endtask

    task automatic test_single_pixel;
        run_frame(2, 1, 3, 0, 100, -1, 1'b0, -1, 1'b1);
        run_frame(2, 1, 2, 50, 40, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) run_frame(0, 50, 2, 25, 70, -1, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset;
        test_frame_basic;
        test_backpressure;
        test_start_ignored;
        test_reset_in_drain;
        test_full_range;
        test_single_pixel;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
